// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated channel multiplexer.
// Mode selectors and the index-width function used by arb_mux and rr_arbiter.
package arb_mux_pkg;

    localparam int RR    = 0;
    localparam int FIXED = 1;

    // Smallest r with 2**r >= n; used to size channel index fields.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Channel arbiter: rotating-priority search from ptr (RR) or lowest-index-wins
// (FIXED), producing a one-hot grant and its encoded index.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = RR,
    parameter int SW   = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] idx;
    int            base;

    // Walk the channels starting at base; the first requester seen wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        base    = (MODE == FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            idx = SW'((base + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // Pointer moves just past the channel that actually transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && gnt_any) begin
            if (gnt_idx == SW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated multiplexer with a single registered output stage that
// drains and refills in the same cycle.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*WIDTH-1:0]    in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(N)-1:0]   out_sel
);

    localparam int SW = clog2(N);

    logic          load;
    logic          accept;
    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic          gnt_any;
    logic [WIDTH-1:0] sel_data;

    assign load     = !out_valid || out_ready;
    assign accept   = load && !rst;
    assign in_ready = grant & {N{accept}};

    rr_arbiter #(
        .N    (N),
        .MODE (MODE),
        .SW   (SW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (accept),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // One-hot select keeps the data path free of any index arithmetic.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load a granted word, or go empty while keeping data/sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench: a round-robin and a fixed-priority arb_mux
// driven by the same inputs, checked against hand-computed values.
module tb_arb_mux;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0]  in_ready_rr, in_ready_fx;
    logic [15:0] out_data_rr, out_data_fx;
    logic        out_valid_rr, out_valid_fx;
    logic [1:0]  out_sel_rr, out_sel_fx;

    int checks;
    int failures;

    arb_mux #(.WIDTH(16), .N(4), .MODE(0)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_rr),
        .out_data  (out_data_rr),
        .out_valid (out_valid_rr),
        .out_ready (out_ready),
        .out_sel   (out_sel_rr)
    );

    arb_mux #(.WIDTH(16), .N(4), .MODE(1)) dut_fx (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_fx),
        .out_data  (out_data_fx),
        .out_valid (out_valid_fx),
        .out_ready (out_ready),
        .out_sel   (out_sel_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic ordy);
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectRr(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
        checkOutput({tag, "_rr_valid"}, 32'(out_valid_rr), 32'(v));
        checkOutput({tag, "_rr_data"},  32'(out_data_rr),  32'(d));
        checkOutput({tag, "_rr_sel"},   32'(out_sel_rr),   32'(s));
    endtask

    task automatic expectFx(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
        checkOutput({tag, "_fx_valid"}, 32'(out_valid_fx), 32'(v));
        checkOutput({tag, "_fx_data"},  32'(out_data_fx),  32'(d));
        checkOutput({tag, "_fx_sel"},   32'(out_sel_fx),   32'(s));
    endtask

    task automatic expectReady(input string tag, input logic [3:0] rr, input logic [3:0] fx);
        checkOutput({tag, "_rr_ready"}, 32'(in_ready_rr), 32'(rr));
        checkOutput({tag, "_fx_ready"}, 32'(in_ready_fx), 32'(fx));
    endtask

    initial begin
        logic [1:0]  exp_sel_seq [0:2];
        checks   = 0;
        failures = 0;
        in_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

        // Reset with all channels requesting: nothing may be accepted.
        applyStimulus(1'b1, 4'b1111, 1'b1);
        expectReady("rst_ready", 4'b0000, 4'b0000);
        tick();
        tick();
        expectRr("rst", 1'b0, 16'h0000, 2'd0);
        expectFx("rst", 1'b0, 16'h0000, 2'd0);

        // Continuous requests: RR rotates 0,1,2,3,0 with no bubble; FIXED stays on 0.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1);
            expectReady($sformatf("rot%0d", k), 4'(1 << (k % 4)), 4'b0001);
            tick();
            expectRr($sformatf("rot%0d", k), 1'b1, 16'hA000 + 16'(k % 4), 2'(k % 4));
            expectFx($sformatf("rot%0d", k), 1'b1, 16'hA000, 2'd0);
        end

        // Channels 1 and 3 requesting; RR ptr starts at 1.
        exp_sel_seq[0] = 2'd1;
        exp_sel_seq[1] = 2'd3;
        exp_sel_seq[2] = 2'd1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b1010, 1'b1);
            expectReady($sformatf("odd%0d", k), 4'(1 << exp_sel_seq[k]), 4'b0010);
            tick();
            expectRr($sformatf("odd%0d", k), 1'b1, 16'hA000 + 16'(exp_sel_seq[k]), exp_sel_seq[k]);
            expectFx($sformatf("odd%0d", k), 1'b1, 16'hA001, 2'd1);
        end

        // Load BEEF from channel 2 (RR ptr is 2), then stall the consumer.
        in_data[47:32] = 16'hBEEF;
        applyStimulus(1'b0, 4'b0100, 1'b1);
        tick();
        expectRr("beef", 1'b1, 16'hBEEF, 2'd2);
        expectFx("beef", 1'b1, 16'hBEEF, 2'd2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0100, 1'b0);
            expectReady($sformatf("stall%0d", k), 4'b0000, 4'b0000);
            tick();
            expectRr($sformatf("stall%0d", k), 1'b1, 16'hBEEF, 2'd2);
            expectFx($sformatf("stall%0d", k), 1'b1, 16'hBEEF, 2'd2);
        end

        // Release: drain and refill on the same edge; RR ptr=3 wraps to channel 0.
        applyStimulus(1'b0, 4'b0001, 1'b1);
        expectReady("wrap", 4'b0001, 4'b0001);
        tick();
        expectRr("wrap", 1'b1, 16'hA000, 2'd0);
        expectFx("wrap", 1'b1, 16'hA000, 2'd0);

        // RR ptr should now be 1.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        expectReady("ptr1", 4'b0010, 4'b0001);
        tick();
        expectRr("ptr1", 1'b1, 16'hA001, 2'd1);
        expectFx("ptr1", 1'b1, 16'hA000, 2'd0);

        // Idle inputs: output empties after one edge while data/sel hold.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1);
            expectReady($sformatf("idle%0d", k), 4'b0000, 4'b0000);
            tick();
            expectRr($sformatf("idle%0d", k), 1'b0, 16'hA001, 2'd1);
            expectFx($sformatf("idle%0d", k), 1'b0, 16'hA000, 2'd0);
        end

        // Fill the register (RR ptr=2 picks BEEF), then reset while stalled.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        tick();
        expectRr("prerst", 1'b1, 16'hBEEF, 2'd2);
        expectFx("prerst", 1'b1, 16'hA000, 2'd0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        expectReady("rst2_ready", 4'b0000, 4'b0000);
        tick();
        expectRr("rst2", 1'b0, 16'h0000, 2'd0);
        expectFx("rst2", 1'b0, 16'h0000, 2'd0);

        // First grant after reset goes to the lowest valid index.
        applyStimulus(1'b0, 4'b1110, 1'b1);
        expectReady("post", 4'b0010, 4'b0010);
        tick();
        expectRr("post", 1'b1, 16'hA001, 2'd1);
        expectFx("post", 1'b1, 16'hA001, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width per channel in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 The block SHALL have parameter MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid  input  N  channel i offers a word.
REQ-008 The block SHALL have port in_ready  output  N  channel i word accepted this cycle when in_valid[i] && in_ready[i].
REQ-009 The block SHALL have port out_data  output  WIDTH  registered selected word.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a word.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-012 The block SHALL have port out_sel  output  clog2(N)  index of the channel that supplied out_data.

Function
REQ-013 load = !out_valid || out_ready; the output register SHALL accept a new word only when load is 1.
REQ-014 Grant SHALL be computed combinationally from in_valid each cycle; at most one in_ready bit SHALL be 1, and in_ready[i] = grant[i] && load.
REQ-015 MODE 1: grant SHALL go to the lowest index i with in_valid[i] = 1.
REQ-016 MODE 0: grant SHALL go to the first i with in_valid[i] = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
REQ-017 MODE 0: on each accepted input transfer from channel g, ptr SHALL become (g+1) mod N; otherwise ptr SHALL hold.
REQ-018 On an accepted transfer, out_data, out_sel and out_valid = 1 SHALL update at the next clock edge (latency 1 cycle).
REQ-019 When load = 1 and no in_valid bit is set, out_valid SHALL become 0 and out_data/out_sel SHALL hold their values.
REQ-020 When out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL hold; all in_ready SHALL be 0.
REQ-021 Simultaneous output drain and input accept in one cycle SHALL be supported, sustaining one word per cycle with no bubble.
REQ-022 in_ready SHALL NOT depend on in_data; in_valid SHALL not be required to stay high once asserted.
REQ-023 Grant SHALL be independent of out_ready except through load (no arbitration change driven by back-pressure).

Reset
REQ-024 While rst = 1 at a clock edge: out_valid SHALL be 0, out_data SHALL be 0, out_sel SHALL be 0, ptr SHALL be 0.
REQ-025 While rst = 1, in_ready SHALL be forced to 0; a word held in the output register at reset SHALL be discarded.
REQ-026 The first grant after rst deasserts SHALL follow REQ-015/016 with ptr = 0.

Structure
REQ-027 Mode constants (RR = 0, FIXED = 1) and the clog2 helper function SHALL reside in the shared package arb_mux_pkg.
REQ-028 Arbitration (ptr register, rotate-search, grant one-hot and encoded index) SHALL be the sub-module rr_arbiter; arb_mux SHALL contain the data select and output register.

Verification
REQ-029 N=4, MODE 0, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1 from cycle 1.
REQ-030 N=4, MODE 1, in_valid=4'b1010, out_ready=1 -> out_sel=1 every cycle; channel 3 never receives in_ready.
REQ-031 Word 16'hBEEF from ch2, out_ready=0 for 3 cycles -> out_data=16'hBEEF, out_valid=1 held, in_ready=0 throughout; on out_ready=1, transfer and next word loads same edge.
REQ-032 MODE 0, ptr=3, in_valid=4'b0001 -> grant ch0 (wrap), ptr becomes 1.
REQ-033 rst asserted for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0; first grant after reset from lowest valid index.
REQ-034 in_valid=0 for 2 cycles after a transfer with out_ready=1 -> out_valid falls after one cycle, out_data holds last value.
